// File: rtl/angle_match_pkg.sv
// angle_match_pkg
// Shared types and helpers for the angle matching stage.
//   state_t   : scan controller states (IDLE, SCAN, DONE)
//   addrWidth : address bits needed to index a table of a given depth
//   distMax   : largest representable distance for a given angle width
package angle_match_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-entry table still needs one address bit to keep port widths legal.
  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // All-ones value of the given width, used to seed the best-distance search.
  function automatic logic [63:0] distMax(input int width);
    return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/angle_match_dist.sv
// angle_dist
// Combinational distance between a phase sample and one table angle.
//   i_angle : signed phase sample
//   i_entry : signed table angle
//   o_dist  : unsigned distance, linear (WRAP=0) or circular mod 2^WIDTH (WRAP=1)
module angle_dist #(
  parameter int WIDTH = 32,
  parameter int WRAP  = 0
) (
  input  logic [WIDTH-1:0] i_angle,
  input  logic [WIDTH-1:0] i_entry,
  output logic [WIDTH-1:0] o_dist
);

  if (WRAP != 0) begin : g_wrap
    // Difference wraps naturally in WIDTH bits; negating the most negative
    // value yields 2^(WIDTH-1) when read as unsigned, which is the intended result.
    logic [WIDTH-1:0] w_d;
    assign w_d    = i_angle - i_entry;
    assign o_dist = w_d[WIDTH-1] ? -w_d : w_d;
  end else begin : g_linear
    // One extra bit keeps the true signed difference; saturate if the
    // magnitude ever spills past WIDTH bits.
    logic [WIDTH:0] w_d;
    logic [WIDTH:0] w_mag;
    assign w_d    = {i_angle[WIDTH-1], i_angle} - {i_entry[WIDTH-1], i_entry};
    assign w_mag  = w_d[WIDTH] ? -w_d : w_d;
    assign o_dist = w_mag[WIDTH] ? {WIDTH{1'b1}} : w_mag[WIDTH-1:0];
  end

endmodule

// File: rtl/angle_match.sv
// angle_match
// Finds the angle-table entry closest to each incoming phase sample by
// walking the table one entry per clock through the RAM's async read port.
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : sample handshake, in_angle is the signed sample
//   ram_address/ram_data: table read port (data is same-cycle combinational)
//   out_valid/out_ready : result handshake, out_index/out_diff is the result
//   busy                : a sample is being scanned or its result is pending
module angle_match
  import angle_match_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 18,
  parameter  int WRAP  = 0,
  localparam int AW    = addrWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_angle,
  output logic [AW-1:0]    ram_address,
  input  logic [WIDTH-1:0] ram_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_index,
  output logic [WIDTH-1:0] out_diff,
  output logic             busy
);

  localparam logic [WIDTH-1:0] DIST_MAX = WIDTH'(distMax(WIDTH));
  localparam logic [AW-1:0]    LAST     = AW'(DEPTH - 1);

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_angle;
  logic [WIDTH-1:0] r_bestDiff;
  logic [AW-1:0]    r_bestIdx;

  logic [WIDTH-1:0] w_dist;
  logic             w_better;
  logic [WIDTH-1:0] w_nextDiff;
  logic [AW-1:0]    w_nextIdx;

  angle_dist #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_dist (
    .i_angle (r_angle),
    .i_entry (ram_data),
    .o_dist  (w_dist)
  );

  // Strict compare so that ties keep the earlier (lower) index, and an entry
  // at DIST_MAX can never displace the seeded best.
  assign w_better   = (w_dist < r_bestDiff);
  assign w_nextDiff = w_better ? w_dist : r_bestDiff;
  assign w_nextIdx  = w_better ? r_addr : r_bestIdx;

  assign ram_address = r_addr;
  assign in_ready    = (r_state == IDLE) && !rst;
  assign busy        = (r_state != IDLE);

  // Scan controller: accept a sample, walk every table entry keeping the
  // running best, then hold the result until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_angle    <= '0;
      r_bestDiff <= '0;
      r_bestIdx  <= '0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_diff   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_addr <= '0;
          if (in_valid) begin
            r_angle    <= in_angle;
            r_bestDiff <= DIST_MAX;
            r_bestIdx  <= '0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          r_bestDiff <= w_nextDiff;
          r_bestIdx  <= w_nextIdx;
          if (r_addr == LAST) begin
            // The last entry is folded in here directly, not via r_best*.
            out_index <= w_nextIdx;
            out_diff  <= w_nextDiff;
            out_valid <= 1'b1;
            r_addr    <= '0;
            r_state   <= DONE;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
